// File: rtl/register_file_fwd.sv
// Decode-stage register file: 32 x 8-bit registers with write-through bypass,
// per-port 4:1 forwarding muxes, an immediate select on port B, and registered A/B operands.
module register_file_fwd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int INS_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INS_W-1:0]  Ins,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic [DATA_W-1:0] mux_ans_dm,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] Imm,
  input  logic [1:0]        mux_sel_a,
  input  logic [1:0]        mux_sel_b,
  input  logic              Imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_DM  = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic [ADDR_W-1:0] rs1, rs2;
  logic              wr_hit;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // The upper instruction field belongs to other stages.
  logic unused_ins;
  assign unused_ins = ^Ins[INS_W-1:2*ADDR_W];

  assign rs1    = Ins[2*ADDR_W-1:ADDR_W];
  assign rs2    = Ins[ADDR_W-1:0];
  assign wr_hit = reg_wr_en && (RW_dm != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    if (wr_hit) regs_d[RW_dm] = mux_ans_dm;
  end

  // Register read with write-through bypass; r0 always reads as zero.
  always_comb begin
    rd_a = regs_q[rs1];
    if (rs1 == '0)                     rd_a = '0;
    else if (wr_hit && RW_dm == rs1)   rd_a = mux_ans_dm;

    rd_b = regs_q[rs2];
    if (rs2 == '0)                     rd_b = '0;
    else if (wr_hit && RW_dm == rs2)   rd_b = mux_ans_dm;
  end

  always_comb begin
    fwd_a = rd_a;
    unique case (fwd_sel_e'(mux_sel_a))
      FWD_REG: fwd_a = rd_a;
      FWD_EX:  fwd_a = ans_ex;
      FWD_DM:  fwd_a = mux_ans_dm;
      FWD_WB:  fwd_a = ans_wb;
      default: fwd_a = rd_a;
    endcase

    fwd_b = rd_b;
    unique case (fwd_sel_e'(mux_sel_b))
      FWD_REG: fwd_b = rd_b;
      FWD_EX:  fwd_b = ans_ex;
      FWD_DM:  fwd_b = mux_ans_dm;
      FWD_WB:  fwd_b = ans_wb;
      default: fwd_b = rd_b;
    endcase
  end

  always_comb begin
    a_d = fwd_a;
    b_d = Imm_sel ? Imm : fwd_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset deliberately; software relies on every register starting at zero.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      regs_q <= regs_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign A = a_q;
  assign B = b_q;

endmodule

// File: tb/tb_register_file_fwd.sv
// Directed bench for register_file_fwd: expected A/B pairs are queued when a step is
// driven and popped for comparison once the DUT has registered them.
module tb_register_file_fwd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] Ins;
  logic        reg_wr_en;
  logic [4:0]  RW_dm;
  logic [7:0]  mux_ans_dm, ans_ex, ans_wb, Imm;
  logic [1:0]  mux_sel_a, mux_sel_b;
  logic        Imm_sel;
  logic [7:0]  A, B;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  register_file_fwd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Ins        (Ins),
    .reg_wr_en  (reg_wr_en),
    .RW_dm      (RW_dm),
    .mux_ans_dm (mux_ans_dm),
    .ans_ex     (ans_ex),
    .ans_wb     (ans_wb),
    .Imm        (Imm),
    .mux_sel_a  (mux_sel_a),
    .mux_sel_b  (mux_sel_b),
    .Imm_sel    (Imm_sel),
    .A          (A),
    .B          (B)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk_ins(input logic [4:0] rs1, input logic [4:0] rs2);
    return {10'h2A5, rs1, rs2};
  endfunction

  task automatic expect_ab(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    e.tag = tag;
    e.a   = ea;
    e.b   = eb;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed size %0d expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (A === e.a) else begin
        n_fail++;
        $error("FAIL %s.A: observed %h expected %h", e.tag, A, e.a);
      end
      n_assert++;
      assert (B === e.b) else begin
        n_fail++;
        $error("FAIL %s.B: observed %h expected %h", e.tag, B, e.b);
      end
    end
  endtask

  // Called 1 time unit after a rising edge: drive, queue expectation, clock, compare.
  task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    expect_ab(tag, ea, eb);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    Ins = '0; reg_wr_en = 1'b0; RW_dm = '0; mux_ans_dm = '0;
    ans_ex = '0; ans_wb = '0; Imm = '0;
    mux_sel_a = 2'b00; mux_sel_b = 2'b00; Imm_sel = 1'b0;

    #2;
    expect_ab("por", 8'h00, 8'h00);
    check_out();
    #1 rst_n = 1'b1;

    // Both ports address r5 while it is written: both see the bypassed value.
    Ins = mk_ins(5'd5, 5'd5); reg_wr_en = 1'b1; RW_dm = 5'd5; mux_ans_dm = 8'hAA;
    step("wr_r5_bypass", 8'hAA, 8'hAA);
    reg_wr_en = 1'b0; mux_ans_dm = 8'h00;
    step("rd_r5_stored", 8'hAA, 8'hAA);

    // Mid-simulation reset clears outputs at once and wipes r5.
    #1 rst_n = 1'b0;
    #1;
    expect_ab("mid_reset", 8'h00, 8'h00);
    check_out();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    Ins = 20'h00043;
    step("rd_r2_r3_after_reset", 8'h00, 8'h00);
    Ins = mk_ins(5'd5, 5'd5);
    step("rd_r5_after_reset", 8'h00, 8'h00);

    // Write r2 with same-cycle bypass, then hold.
    Ins = 20'h00043; RW_dm = 5'd2; mux_ans_dm = 8'h10; reg_wr_en = 1'b1;
    step("wr_r2_bypass", 8'h10, 8'h00);
    reg_wr_en = 1'b0;
    step("rd_r2_hold", 8'h10, 8'h00);

    // Immediate overrides any forwarding select on B.
    Imm = 8'h60; Imm_sel = 1'b1; mux_sel_b = 2'b00;
    step("imm_sel00", 8'h10, 8'h60);
    mux_sel_b = 2'b11; ans_wb = 8'h5C;
    step("imm_sel11", 8'h10, 8'h60);

    // Forwarding sources.
    ans_ex = 8'h30; mux_ans_dm = 8'h40; ans_wb = 8'h50; Imm_sel = 1'b0;
    mux_sel_a = 2'b01; mux_sel_b = 2'b00;
    step("fwd_a_ex", 8'h30, 8'h00);
    mux_sel_a = 2'b10; mux_sel_b = 2'b11;
    step("fwd_a_dm_b_wb", 8'h40, 8'h50);
    mux_sel_a = 2'b11; mux_sel_b = 2'b01;
    step("fwd_a_wb_b_ex", 8'h50, 8'h30);
    mux_sel_a = 2'b00; mux_sel_b = 2'b10;
    step("fwd_a_reg_b_dm", 8'h10, 8'h40);
    mux_sel_a = 2'b01; mux_sel_b = 2'b01;
    step("fwd_both_ex", 8'h30, 8'h30);
    mux_sel_a = 2'b00; mux_sel_b = 2'b00;

    // Write to an address not being read must not bypass; then read it back on B.
    RW_dm = 5'd7; mux_ans_dm = 8'h77; reg_wr_en = 1'b1;
    step("wr_r7_no_bypass", 8'h10, 8'h00);
    reg_wr_en = 1'b0; Ins = mk_ins(5'd2, 5'd7);
    step("rd_r7_on_b", 8'h10, 8'h77);
    Ins = mk_ins(5'd2, 5'd3); RW_dm = 5'd3; mux_ans_dm = 8'h33; reg_wr_en = 1'b1;
    step("wr_r3_bypass_b", 8'h10, 8'h33);
    Ins = mk_ins(5'd31, 5'd3); RW_dm = 5'd31; mux_ans_dm = 8'hE1;
    step("wr_r31_bypass_a", 8'hE1, 8'h33);
    reg_wr_en = 1'b0; mux_ans_dm = 8'h00;
    step("rd_r31_stored", 8'hE1, 8'h33);

    // r0 protection: write to address 0 is ignored and never bypassed.
    Ins = mk_ins(5'd0, 5'd0); RW_dm = 5'd0; mux_ans_dm = 8'hFF; reg_wr_en = 1'b1;
    step("wr_r0_ignored", 8'h00, 8'h00);
    reg_wr_en = 1'b0;
    step("rd_r0_zero", 8'h00, 8'h00);

    // Async reset with a write pending on r2: the write is discarded.
    Ins = 20'h00043; RW_dm = 5'd2; mux_ans_dm = 8'h99; reg_wr_en = 1'b1;
    step("wr_r2_99", 8'h99, 8'h33);
    mux_ans_dm = 8'h55;
    #2 rst_n = 1'b0;
    #1;
    expect_ab("async_reset_pending_wr", 8'h00, 8'h00);
    check_out();
    @(posedge clk); #1;
    expect_ab("reset_held_over_edge", 8'h00, 8'h00);
    check_out();
    reg_wr_en = 1'b0; mux_ans_dm = 8'h00;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step("rd_r2_after_async_reset", 8'h00, 8'h00);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
